// File: rtl/vecgate_scheduler.sv
// Round-robin scheduler time-sharing one 3-bit vector-logic unit among NREQ requesters.
// Flow is IDLE (arbitrate/capture) -> EXEC (compute/register) -> HOLD (wait for consumer).
module vecgate_scheduler #(
    parameter int NREQ = 3,
    parameter int IDW  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [3*NREQ-1:0]    req_a,
    input  logic [3*NREQ-1:0]    req_b,
    input  logic [2*NREQ-1:0]    req_op,
    output logic [NREQ-1:0]      gnt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5:0]           out_data,
    output logic [IDW-1:0]       out_id,
    output logic                 out_err,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [2:0]        a_q, a_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              ov_q, ov_d;
    logic [5:0]        data_q, data_d;
    logic [IDW-1:0]    oid_q, oid_d;
    logic              err_q, err_d;

    logic [2*NREQ-1:0] req_rot;
    logic [IDW:0]      win_sum;
    logic [IDW-1:0]    win_id;
    logic [2:0]        a_sel, b_sel;
    logic [1:0]        op_sel;
    logic [NREQ-1:0]   win_oh;
    logic [5:0]        res;
    logic              res_err;

    // Rotate so bit 0 is the requester at the rr pointer; lowest set bit wins.
    assign req_rot = {req, req} >> rr_q;

    always_comb begin
        win_sum = {1'b0, rr_q};
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) win_sum = {1'b0, rr_q} + (IDW+1)'(k);
        end
        if (win_sum >= (IDW+1)'(NREQ)) win_sum = win_sum - (IDW+1)'(NREQ);
        win_id = win_sum[IDW-1:0];
    end

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = '0;
        win_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == IDW'(i)) begin
                a_sel     = req_a[3*i +: 3];
                b_sel     = req_b[3*i +: 3];
                op_sel    = req_op[2*i +: 2];
                win_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        res     = '0;
        res_err = 1'b0;
        case (op_q)
            2'b00:   res = {3'b000, a_q | b_q};
            2'b01:   res = {5'b0, (a_q != 3'b000) || (b_q != 3'b000)};
            2'b10:   res = {~b_q, ~a_q};
            default: res_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        gnt_d   = '0;
        ov_d    = ov_q;
        data_d  = data_q;
        oid_d   = oid_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    id_d    = win_id;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    op_d    = op_sel;
                    gnt_d   = win_oh;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                data_d  = res;
                err_d   = res_err;
                oid_d   = id_q;
                ov_d    = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    rr_d    = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            gnt_q   <= '0;
            ov_q    <= 1'b0;
            data_q  <= '0;
            oid_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            gnt_q   <= gnt_d;
            ov_q    <= ov_d;
            data_q  <= data_d;
            oid_q   <= oid_d;
            err_q   <= err_d;
        end
    end

    assign gnt       = gnt_q;
    assign out_valid = ov_q;
    assign out_data  = data_q;
    assign out_id    = oid_q;
    assign out_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vecgate_scheduler.sv
// Bench for vecgate_scheduler: table of single ops plus hand-written arbitration,
// backpressure, reset and wrap sequences, with results checked from a scoreboard queue.
module tb_vecgate_scheduler;
    localparam int NREQ = 3;
    localparam int IDW  = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [3*NREQ-1:0]   req_a, req_b;
    logic [2*NREQ-1:0]   req_op;
    logic [NREQ-1:0]     gnt;
    logic                out_valid, out_ready;
    logic [5:0]          out_data;
    logic [IDW-1:0]      out_id;
    logic                out_err, busy;

    vecgate_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [5:0]     data;
        logic           err;
    } exp_t;

    typedef struct {
        int         rid;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] op;
        logic [5:0] data;
        logic       err;
    } vec_t;

    exp_t q[$];
    vec_t vecs[9];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        nvec++;
        nerr++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Result checker: consume one expectation per accepted handshake.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t e;
            if (q.size() == 0) fail("unexpected result");
            else begin
                e = q.pop_front();
                chk("out_id", 32'(out_id), 32'(e.id));
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    task automatic set_ops(input int rid, input logic [2:0] a, input logic [2:0] b, input logic [1:0] op);
        req_a[3*rid +: 3]  = a;
        req_b[3*rid +: 3]  = b;
        req_op[2*rid +: 2] = op;
    endtask

    task automatic wait_gnt(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (gnt == '0 && lat < 20);
        if (gnt == '0) fail("gnt timeout");
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        if (q.size() != 0) begin
            fail("result timeout");
            q.delete();
        end
    endtask

    task automatic issue(input logic [NREQ-1:0] m, input logic [IDW-1:0] eid,
                         input logic [5:0] ed, input logic ee);
        int lat;
        logic [NREQ-1:0] eg;
        eg  = '0;
        eg[eid] = 1'b1;
        req = m;
        wait_gnt(lat);
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt latency", 32'(lat), 32'd1);
        chk("busy in exec", 32'(busy), 32'd1);
        req = '0;
        q.push_back('{eid, ed, ee});
        @(posedge clk); #1;
        chk("out_valid rise", 32'(out_valid), 32'd1);
        drain();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int lat;
        logic [NREQ-1:0] eg;

        #200000;
        $display("FAIL global timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat;
        logic [NREQ-1:0] eg;

        reset = 1'b1; req = '0; req_a = '0; req_b = '0; req_op = '0; out_ready = 1'b1;
        do_reset();
        chk("reset gnt", 32'(gnt), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset out_id", 32'(out_id), 32'd0);
        chk("reset out_err", 32'(out_err), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);

        vecs = '{
            '{0, 3'b101, 3'b010, 2'b00, 6'b000111, 1'b0},
            '{1, 3'b000, 3'b000, 2'b01, 6'b000000, 1'b0},
            '{1, 3'b000, 3'b100, 2'b01, 6'b000001, 1'b0},
            '{1, 3'b110, 3'b001, 2'b10, 6'b110001, 1'b0},
            '{1, 3'b011, 3'b101, 2'b11, 6'b000000, 1'b1},
            '{2, 3'b100, 3'b001, 2'b00, 6'b000101, 1'b0},
            '{2, 3'b111, 3'b000, 2'b10, 6'b111000, 1'b0},
            '{0, 3'b010, 3'b000, 2'b01, 6'b000001, 1'b0},
            '{2, 3'b000, 3'b000, 2'b10, 6'b111111, 1'b0}
        };
        for (int i = 0; i < 9; i++) begin
            set_ops(vecs[i].rid, vecs[i].a, vecs[i].b, vecs[i].op);
            issue(NREQ'(1) << vecs[i].rid, IDW'(vecs[i].rid), vecs[i].data, vecs[i].err);
        end

        // Fairness: all requesters held high, one grant every 3 cycles in order 0,1,2,...
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 3'(i + 1), 3'b000, 2'b00);
        req = '1;
        for (int g = 0; g < 6; g++) begin
            wait_gnt(lat);
            eg = '0;
            eg[g % NREQ] = 1'b1;
            chk("rr gnt", 32'(gnt), 32'(eg));
            chk("rr interval", 32'(lat), (g == 0) ? 32'd1 : 32'd3);
            q.push_back('{IDW'(g % NREQ), {3'b000, 3'((g % NREQ) + 1)}, 1'b0});
        end
        req = '0;
        drain();

        // Backpressure: result held stable, competing request ignored until retirement.
        out_ready = 1'b0;
        set_ops(0, 3'b001, 3'b100, 2'b00);
        req = 3'b001;
        wait_gnt(lat);
        chk("bp gnt", 32'(gnt), 32'b001);
        req = '0;
        q.push_back('{IDW'(0), 6'b000101, 1'b0});
        @(posedge clk); #1;
        chk("bp out_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                set_ops(1, 3'b000, 3'b111, 2'b10);
                req = 3'b010;
            end
            @(posedge clk); #1;
            chk("bp hold valid", 32'(out_valid), 32'd1);
            chk("bp hold data", 32'(out_data), 32'b000101);
            chk("bp hold id", 32'(out_id), 32'd0);
            chk("bp no gnt", 32'(gnt), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp retired", 32'(out_valid), 32'd0);
        chk("bp gnt wait", 32'(gnt), 32'd0);
        @(posedge clk); #1;
        chk("bp late gnt", 32'(gnt), 32'b010);
        req = '0;
        q.push_back('{IDW'(1), 6'b000111, 1'b0});
        drain();

        // Reset during EXEC abandons the op and returns the pointer to 0.
        set_ops(0, 3'b111, 3'b111, 2'b00);
        req = 3'b001;
        wait_gnt(lat);
        chk("mid gnt", 32'(gnt), 32'b001);
        reset = 1'b1;
        req   = '0;
        @(posedge clk); #1;
        chk("mid out_valid", 32'(out_valid), 32'd0);
        chk("mid busy", 32'(busy), 32'd0);
        chk("mid gnt clr", 32'(gnt), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid no result", 32'(out_valid), 32'd0);
        set_ops(1, 3'b001, 3'b000, 2'b01);
        set_ops(2, 3'b110, 3'b001, 2'b00);
        req = 3'b110;
        wait_gnt(lat);
        chk("post-reset gnt", 32'(gnt), 32'b010);
        req = 3'b100;
        q.push_back('{IDW'(1), 6'b000001, 1'b0});
        wait_gnt(lat);
        chk("next gnt", 32'(gnt), 32'b100);
        req = '0;
        q.push_back('{IDW'(2), 6'b000111, 1'b0});
        drain();

        // Wrap-around: after requester 2 retires, requester 0 wins over 2.
        set_ops(0, 3'b010, 3'b010, 2'b11);
        set_ops(2, 3'b000, 3'b000, 2'b01);
        req = 3'b101;
        wait_gnt(lat);
        chk("wrap gnt", 32'(gnt), 32'b001);
        req = 3'b100;
        q.push_back('{IDW'(0), 6'b000000, 1'b1});
        wait_gnt(lat);
        chk("wrap gnt2", 32'(gnt), 32'b100);
        req = '0;
        q.push_back('{IDW'(2), 6'b000000, 1'b0});
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/vecgate_scheduler.md
Name: vecgate_scheduler

Overview:
- Time-shares one 3-bit vector-logic unit among NREQ requesters.
- Unit operations: bitwise OR, logical OR, and concatenated NOT {~b,~a}.
- Round-robin arbitration; one operation in flight at a time.
- Registered 6-bit result returned with requester ID over a valid/ready handshake.
- Sits between the operand-producing blocks and a single shared result consumer.

Parameters:
NREQ, 3, number of requesters (2..8)
IDW, 3, width of grant ID output; must satisfy 2**IDW >= NREQ

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  NREQ  per-requester request; held high with operands stable until its gnt bit pulses
req_a  input  3*NREQ  operand a; requester i on bits [3i+2:3i]
req_b  input  3*NREQ  operand b; same packing as req_a
req_op  input  2*NREQ  opcode; requester i on bits [2i+1:2i]
gnt  output  NREQ  one-hot, one-cycle pulse: request accepted, operands captured
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  6  result
out_id  output  IDW  index of the requester that owns out_data
out_err  output  1  opcode was reserved (11); qualified by out_valid
busy  output  1  high in EXEC and HOLD

Behaviour:
- Clock is clk. Reset is synchronous and active-high on port reset.
- Reset: all of the following are forced to 0: gnt, out_valid, out_data, out_id, out_err, busy, state (IDLE), rr pointer.
- Reset mid-operation abandons the in-flight operation with no gnt or result.
- States:
  - IDLE: if any req bit is high at an edge, select the winner, capture its a/b/op, pulse gnt[winner], go to EXEC. Otherwise stay in IDLE.
  - EXEC: compute from the captured operands, register out_data/out_id/out_err, set out_valid=1, go to HOLD.
  - HOLD: out_valid=1; out_data, out_id and out_err are stable. At an edge with out_ready=1: out_valid<=0, rr pointer <= (winner+1) mod NREQ, go to IDLE.
- Arbitration: winner is the first asserted req scanning from the rr pointer upward, with wrap-around.
- A requester that is never granted keeps its priority; the rr pointer advances only on result retirement.
- Timing:
  - gnt is visible the cycle after req is sampled.
  - out_valid rises 2 cycles after req is sampled.
  - Minimum issue interval is 3 cycles (IDLE→EXEC→HOLD→IDLE with out_ready held high).
- Requester obligations:
  - Drop req in the cycle gnt is seen. A req still high when the block returns to IDLE is treated as a new request.
  - req is ignored while busy=1. Requests are never queued.
- Opcodes (a, b are the captured 3-bit operands):
  - 00: out_data = {3'b000, a|b}
  - 01: out_data = {5'b0, (a!=0)||(b!=0)}
  - 10: out_data = {~b, ~a}; b occupies [5:3], a occupies [2:0]
  - 11: out_data = 6'b0, out_err = 1
- out_ready is ignored when out_valid=0.
- Simultaneous reset and out_ready: reset wins.

Test Plan:
- Reset and single op: after reset, req=3'b001, a0=3'b101, b0=3'b010, op0=00 → gnt=001 one cycle later; then out_valid=1, out_data=6'b000111, out_id=0, out_err=0.
- Op coverage on requester 1:
  - op=01, a=000, b=000 → out_data=6'b000000.
  - op=01, a=000, b=100 → out_data=6'b000001.
  - op=10, a=3'b110, b=3'b001 → out_data=6'b110001.
  - op=11 → out_data=0, out_err=1.
- Round-robin fairness: all three req held high continuously, out_ready=1 → grant order 0,1,2,0,… with one gnt every 3 cycles, and no requester granted twice before the others.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out_valid, out_data and out_id stay constant. A new req during this window gets no gnt; it is granted 1 cycle after out_ready=1 retires the result.
- Reset mid-operation: assert reset in EXEC → next cycle out_valid=0 and state IDLE. With req=3'b110 afterwards, requester 1 wins because the pointer is back at 0.
- Wrap-around: after requester 2 retires, with req=3'b101 → requester 0 wins.
